// File: rtl/lsu_axi_master.sv
// lsu_axi_master
//   Memory-stage request engine feeding the LSU over AXI-lite-style channels.
//   It accepts one load or store per req handshake and keeps one transaction
//   outstanding at a time. Store data and byte strobes are aligned to the
//   byte lane of the address. The engine returns either the raw read word or
//   a store completion. Load sign/zero extension is left to the LSU.
//
// Parameters:
//   TIMEOUT_CYCLES  bus-wait limit before a transaction is forced to error.
//                   It only has an effect when LSU_TIMEOUT_EN is defined.
//
// Build option:
//   LSU_TIMEOUT_EN  adds a 16-bit bus-wait counter and the timeout error path.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           request handshake from the pipeline
//   req_wen/addr/size/wdata       request fields (size: 0=B, 1=H, 2=W, 3=illegal)
//   resp_valid/resp_ready         result handshake to writeback
//   resp_rdata/resp_err           raw read word (0 for stores) and error flag
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel
module lsu_axi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RESP
  } state_t;

  state_t      state, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        misaligned;
  logic [3:0]  strb_base;
  logic        timeout_hit;

  // Alignment check and the unshifted strobe pattern for the access size.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = 4'b0000;
    case (req_size)
      2'd0: strb_base = 4'b0001;
      2'd1: begin
        strb_base  = 4'b0011;
        misaligned = req_addr[0];
      end
      2'd2: begin
        strb_base  = 4'b1111;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        busy;

  assign busy = (state == RADDR) || (state == RDATA) ||
                (state == WRITE) || (state == WRESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign timeout_hit = busy && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  // No counter in this build; the parameter is referenced only to keep the
  // parameter list identical across both builds.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
          wstrb_d   = strb_base << req_addr[1:0];
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_wen) begin
            state_d = WRITE;
          end else begin
            state_d = RADDR;
          end
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = rresp;
          state_d = RESP;
        end
      end
      WRITE: begin
        // AW and W retire independently; the done flags drop each valid
        // as soon as its own handshake has happened.
        if (awready && !aw_done_q) aw_done_d = 1'b1;
        if (wready && !w_done_q) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          err_d   = bresp;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A timeout overrides any handshake in the same cycle.
    if (timeout_hit) begin
      state_d = RESP;
      err_d   = 1'b1;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Channel controls decode straight from registered state, so each one
  // rises the cycle after acceptance and holds until its handshake.
  assign req_ready  = (state == IDLE);
  assign arvalid    = (state == RADDR);
  assign araddr     = arvalid ? addr_q : '0;
  assign rready     = (state == RDATA);
  assign awvalid    = (state == WRITE) && !aw_done_q;
  assign wvalid     = (state == WRITE) && !w_done_q;
  assign awaddr     = (state == WRITE) ? addr_q : '0;
  assign wdata      = (state == WRITE) ? wdata_q : '0;
  assign wstrb      = (state == WRITE) ? wstrb_q : '0;
  assign bready     = (state == WRESP);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
module tb_lsu_axi_master;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rresp, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0]  wstrb;

  lsu_axi_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ar_seen  = 0;
  int   ar_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid) ar_seen++;
      if (resp_valid && resp_ready) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_resp: observed rdata %h err %b expected no response",
                 resp_rdata, resp_err);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && req_ready) begin
        done = 1'b1;
        break;
      end
      tick;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = '0; req_size = '0; req_wdata = '0;
    resp_ready = 1'b1;
    arready = 0; rdata = '0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, resp_valid, 1'b0}, 32'd0);
    chk("rst_readies", {30'd0, rready, bready}, 32'd0);
    chk("rst_addr", araddr | awaddr | wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_resp", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    tick;

    // Load word, arready at cycle 2, rvalid at cycle 4.
    sb.push_back('{32'hDEADBEEF, 1'b0});
    issue(1'b0, 32'h8000_0010, 2'd2, '0);
    chk("ld_arvalid", 32'(arvalid), 32'd1);
    chk("ld_araddr", araddr, 32'h8000_0010);
    chk("ld_req_ready_busy", 32'(req_ready), 32'd0);
    tick;
    chk("ld_arvalid_hold", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("ld_arvalid_drop", 32'(arvalid), 32'd0);
    chk("ld_rready", 32'(rready), 32'd1);
    rdata = 32'hDEADBEEF;
    tick;
    chk("ld_rready_hold", 32'(rready), 32'd1);
    rvalid = 1'b1;
    tick;
    rvalid = 1'b0; rdata = '0;
    chk("ld_resp_valid", 32'(resp_valid), 32'd1);
    drain;

    // Store byte, AW three cycles before W.
    sb.push_back('{32'h0, 1'b0});
    issue(1'b1, 32'h8000_0003, 2'd0, 32'h0000_00AB);
    chk("sb_awvalid", 32'(awvalid), 32'd1);
    chk("sb_wvalid", 32'(wvalid), 32'd1);
    chk("sb_awaddr", awaddr, 32'h8000_0003);
    chk("sb_wdata", wdata, 32'hAB00_0000);
    chk("sb_wstrb", 32'(wstrb), 32'h8);
    awready = 1'b1;
    tick;
    awready = 1'b0;
    chk("sb_awvalid_done", 32'(awvalid), 32'd0);
    chk("sb_wvalid_hold", 32'(wvalid), 32'd1);
    tick; tick;
    chk("sb_wdata_hold", wdata, 32'hAB00_0000);
    wready = 1'b1;
    tick;
    wready = 1'b0;
    chk("sb_wvalid_done", 32'(wvalid), 32'd0);
    chk("sb_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    drain;

    // Store half, AW and W in the same cycle.
    sb.push_back('{32'h0, 1'b0});
    issue(1'b1, 32'h8000_0002, 2'd1, 32'h0000_1234);
    chk("sh_wdata", wdata, 32'h1234_0000);
    chk("sh_wstrb", 32'(wstrb), 32'hC);
    awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    chk("sh_valids_done", {30'd0, awvalid, wvalid}, 32'd0);
    chk("sh_bready", 32'(bready), 32'd1);
    tick;
    chk("sh_bready_hold", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    drain;

    // Misaligned / illegal requests: immediate error, no bus traffic.
    ar_before = ar_seen;
    sb.push_back('{32'h0, 1'b1});
    issue(1'b0, 32'h8000_0002, 2'd2, '0);
    chk("mis_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_resp_err", 32'(resp_err), 32'd1);
    chk("mis_arvalid", 32'(arvalid), 32'd0);
    drain;
    sb.push_back('{32'h0, 1'b1});
    issue(1'b0, 32'h8000_0000, 2'd3, '0);
    chk("sz3_resp_valid", 32'(resp_valid), 32'd1);
    chk("sz3_resp_err", 32'(resp_err), 32'd1);
    drain;
    sb.push_back('{32'h0, 1'b1});
    issue(1'b1, 32'h8000_0001, 2'd1, 32'h5555);
    chk("mis_st_err", 32'(resp_err), 32'd1);
    chk("mis_st_valids", {30'd0, awvalid, wvalid}, 32'd0);
    drain;
    chk("mis_no_ar", 32'(ar_seen), 32'(ar_before));

    // Load with read error, consumer stalls five cycles.
    resp_ready = 1'b0;
    sb.push_back('{32'h1234_5678, 1'b1});
    issue(1'b0, 32'h8000_0020, 2'd2, '0);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 1'b1;
    tick;
    rvalid = 1'b0; rdata = '0; rresp = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0100; req_size = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_resp_rdata", resp_rdata, 32'h1234_5678);
      chk("stall_resp_err", 32'(resp_err), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      tick;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    chk("no_same_cycle_accept", 32'(req_ready), 32'd0);
    drain;
    chk("ignored_no_awvalid", 32'(awvalid), 32'd0);
    rvalid = 1'b1;
    tick;
    chk("idle_rready", 32'(rready), 32'd0);
    rvalid = 1'b0;

    // Reset while waiting in RDATA abandons the load.
    issue(1'b0, 32'h8000_0030, 2'd2, '0);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("rstmid_rready", 32'(rready), 32'd1);
    rst = 1'b1;
    tick;
    chk("rstmid_valids", {27'd0, arvalid, awvalid, wvalid, resp_valid, 1'b0}, 32'd0);
    chk("rstmid_readies", {30'd0, rready, bready}, 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    tick;
    chk("rstmid_late_rready", 32'(rready), 32'd0);
    rvalid = 1'b0; rdata = '0;
    tick; tick;

    // Recovery load after reset.
    sb.push_back('{32'hCAFE_F00D, 1'b0});
    issue(1'b0, 32'h8000_0040, 2'd2, '0);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick;
    rvalid = 1'b0; rdata = '0;
    drain;

`ifdef LSU_TIMEOUT_EN
    // Timeout with arready held low.
    resp_ready = 1'b0;
    sb.push_back('{32'h0, 1'b1});
    issue(1'b0, 32'h8000_0050, 2'd2, '0);
    chk("tmo_c0_resp_valid", 32'(resp_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("tmo_resp_valid", 32'(resp_valid), 32'(k == 8));
      chk("tmo_arvalid", 32'(arvalid), 32'(k != 8));
    end
    chk("tmo_resp_err", 32'(resp_err), 32'd1);
    chk("tmo_resp_rdata", resp_rdata, 32'd0);
    rvalid = 1'b1; rdata = 32'h7777_7777;
    resp_ready = 1'b1;
    drain;
    chk("tmo_late_rready", 32'(rready), 32'd0);
    rvalid = 1'b0; rdata = '0;
    tick;
`endif

    tick;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
